// File: rtl/tron_control_fsm.sv
// Multi-cycle control sequencer for the Tron 16-bit datapath.
// FETCH/MEM wait on memReady. A watchdog halts with a sticky busError if memory never answers.
module tron_control_fsm #(
    parameter int TIMEOUT  = 255,
    parameter int TO_WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instructionOp,
    input  logic       condTrue,
    input  logic       memReady,
    output logic       pcEn,
    output logic [1:0] pcSrc,
    output logic       irWrite,
    output logic       memReq,
    output logic       memWrite,
    output logic       addrSel,
    output logic       regWrite,
    output logic [1:0] wbSel,
    output logic       aluSrcImm,
    output logic       flagsWrite,
    output logic       halted,
    output logic       busError,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LOAD  = 8'h40;
    localparam logic [7:0] OP_STOR  = 8'h44;
    localparam logic [7:0] OP_JAL   = 8'h48;
    localparam logic [7:0] OP_JCOND = 8'h4C;
    localparam logic [7:0] OP_BCOND = 8'hC0;

    localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT);
    localparam logic [TO_WIDTH-1:0] TO_MAX   = {TO_WIDTH{1'b1}};
    localparam logic [TO_WIDTH-1:0] TO_ONE   = {{(TO_WIDTH-1){1'b0}}, 1'b1};

    state_t              r_state, w_state_next;
    logic [TO_WIDTH-1:0] r_wait_cnt, w_wait_next;
    logic                r_bus_error, w_bus_error_next;
    logic                w_is_alu_reg, w_is_imm, w_is_cmp, w_sets_flags, w_timeout;

    always_comb begin
        w_is_alu_reg = 1'b0;
        w_is_imm     = 1'b0;
        case (instructionOp)
            8'h05, 8'h09, 8'h0B, 8'h01, 8'h02, 8'h03, 8'h0D, 8'h84: w_is_alu_reg = 1'b1;
            8'h50, 8'h90, 8'hB0, 8'h10, 8'h20, 8'h30, 8'hD0, 8'hF0,
            8'h80, 8'h81: w_is_imm = 1'b1;
            default: ;
        endcase
    end

    assign w_is_cmp     = (instructionOp == 8'h0B) || (instructionOp == 8'hB0);
    assign w_sets_flags = (instructionOp == 8'h05) || (instructionOp == 8'h50) ||
                          (instructionOp == 8'h09) || (instructionOp == 8'h90) || w_is_cmp;
    // A ready arriving on the limit cycle still completes normally.
    assign w_timeout    = (TIMEOUT != 0) && (r_wait_cnt == TO_LIMIT) && !memReady;

    always_comb begin
        w_state_next     = r_state;
        w_bus_error_next = r_bus_error;
        pcEn       = 1'b0;
        pcSrc      = 2'd0;
        irWrite    = 1'b0;
        memReq     = 1'b0;
        memWrite   = 1'b0;
        addrSel    = 1'b0;
        regWrite   = 1'b0;
        wbSel      = 2'd0;
        aluSrcImm  = 1'b0;
        flagsWrite = 1'b0;
        halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                memReq = 1'b1;
                if (memReady) begin
                    irWrite      = 1'b1;
                    pcEn         = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_timeout) begin
                    w_state_next     = S_HALT;
                    w_bus_error_next = 1'b1;
                end
            end
            S_DECODE: begin
                w_state_next = S_FETCH;
                if (w_is_alu_reg || w_is_imm) begin
                    w_state_next = S_EXEC;
                end else if (instructionOp == OP_LOAD || instructionOp == OP_STOR) begin
                    w_state_next = S_MEM;
                end else if (instructionOp == OP_BCOND) begin
                    pcEn  = condTrue;
                    pcSrc = condTrue ? 2'd1 : 2'd0;
                end else if (instructionOp == OP_JCOND) begin
                    pcEn  = condTrue;
                    pcSrc = condTrue ? 2'd2 : 2'd0;
                end else if (instructionOp == OP_JAL) begin
                    // PC already holds the incremented value, so it is the link.
                    regWrite = 1'b1;
                    wbSel    = 2'd2;
                    pcEn     = 1'b1;
                    pcSrc    = 2'd2;
                end else if (instructionOp != OP_NOP) begin
                    w_state_next = S_HALT;
                end
            end
            S_EXEC: begin
                regWrite     = !w_is_cmp;
                aluSrcImm    = w_is_imm;
                flagsWrite   = w_sets_flags;
                w_state_next = S_FETCH;
            end
            S_MEM: begin
                memReq   = 1'b1;
                addrSel  = 1'b1;
                memWrite = (instructionOp == OP_STOR);
                if (memReady) begin
                    w_state_next = (instructionOp == OP_LOAD) ? S_WB : S_FETCH;
                end else if (w_timeout) begin
                    w_state_next     = S_HALT;
                    w_bus_error_next = 1'b1;
                end
            end
            S_WB: begin
                regWrite     = 1'b1;
                wbSel        = 2'd1;
                w_state_next = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: w_state_next = S_FETCH;
        endcase
        state    = r_state;
        busError = r_bus_error;
        if (!reset) begin
            pcEn       = 1'b0;
            pcSrc      = 2'd0;
            irWrite    = 1'b0;
            memReq     = 1'b0;
            memWrite   = 1'b0;
            addrSel    = 1'b0;
            regWrite   = 1'b0;
            wbSel      = 2'd0;
            aluSrcImm  = 1'b0;
            flagsWrite = 1'b0;
            halted     = 1'b0;
            busError   = 1'b0;
            state      = 3'd0;
        end
    end

    always_comb begin
        w_wait_next = r_wait_cnt;
        if (w_state_next != r_state) begin
            w_wait_next = '0;
        end else if ((r_state == S_FETCH || r_state == S_MEM) && !memReady &&
                     (r_wait_cnt != TO_MAX)) begin
            w_wait_next = r_wait_cnt + TO_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_FETCH;
            r_wait_cnt  <= '0;
            r_bus_error <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wait_cnt  <= w_wait_next;
            r_bus_error <= w_bus_error_next;
        end
    end
endmodule

// File: tb/tb_tron_control_fsm.sv
// Directed bench for tron_control_fsm with a short watchdog (TIMEOUT = 4).
// Outputs are packed into one vector and compared against hand-built expectations.
module tb_tron_control_fsm;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instructionOp;
    logic       condTrue;
    logic       memReady;
    logic       pcEn, irWrite, memReq, memWrite, addrSel, regWrite;
    logic       aluSrcImm, flagsWrite, halted, busError;
    logic [1:0] pcSrc, wbSel;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    logic [16:0] e;
    logic [16:0] obs;

    tron_control_fsm #(.TIMEOUT(4), .TO_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .instructionOp(instructionOp), .condTrue(condTrue),
        .memReady(memReady), .pcEn(pcEn), .pcSrc(pcSrc), .irWrite(irWrite),
        .memReq(memReq), .memWrite(memWrite), .addrSel(addrSel), .regWrite(regWrite),
        .wbSel(wbSel), .aluSrcImm(aluSrcImm), .flagsWrite(flagsWrite),
        .halted(halted), .busError(busError), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {state, pcEn, pcSrc, irWrite, memReq, memWrite, addrSel,
                  regWrite, wbSel, aluSrcImm, flagsWrite, halted, busError};

    // Field order: state pcEn pcSrc irWrite memReq memWrite addrSel regWrite wbSel imm flagsW halted busErr
    function automatic logic [16:0] ev(input logic [2:0] st, input logic pe, input logic [1:0] ps,
                                       input logic irw, input logic mr, input logic mw,
                                       input logic as, input logic rw, input logic [1:0] wb,
                                       input logic im, input logic fw, input logic hl,
                                       input logic be);
        return {st, pe, ps, irw, mr, mw, as, rw, wb, im, fw, hl, be};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0; instructionOp = 8'h40; condTrue = 1'b0; memReady = 1'b0;
        #1;
        e = ev(0,0,0,0,0,0,0,0,0,0,0,0,0);
        checks++; if (obs !== e) begin errors++; $display("FAIL reset_hold got=%h exp=%h", obs, e); end
        step();
        reset = 1'b1;
        #1;
        e = ev(0,0,0,0,1,0,0,0,0,0,0,0,0);
        checks++; if (obs !== e) begin errors++; $display("FAIL reset_release got=%h exp=%h", obs, e); end
        memReady = 1'b1; step(); memReady = 1'b0; #1;
        e = ev(1,0,0,0,0,0,0,0,0,0,0,0,0);
        checks++; if (obs !== e) begin errors++; $display("FAIL reset_decode got=%h exp=%h", obs, e); end
        step(); #1;
        e = ev(3,0,0,0,1,0,1,0,0,0,0,0,0);
        checks++; if (obs !== e) begin errors++; $display("FAIL reset_in_mem got=%h exp=%h", obs, e); end
        reset = 1'b0; #1;
        e = ev(0,0,0,0,0,0,0,0,0,0,0,0,0);
        checks++; if (obs !== e) begin errors++; $display("FAIL reset_abort got=%h exp=%h", obs, e); end
        step(); reset = 1'b1; #1;
        e = ev(0,0,0,0,1,0,0,0,0,0,0,0,0);
        checks++; if (obs !== e) begin errors++; $display("FAIL reset_refetch got=%h exp=%h", obs, e); end
    endtask

    task automatic test_alu_add();
        instructionOp = 8'h05; memReady = 1'b1; #1;
        e = ev(0,1,0,1,1,0,0,0,0,0,0,0,0);
        checks++; if (obs !== e) begin errors++; $display("FAIL add_fetch got=%h exp=%h", obs, e); end
        step(); memReady = 1'b0; #1;
        e = ev(1,0,0,0,0,0,0,0,0,0,0,0,0);
        checks++; if (obs !== e) begin errors++; $display("FAIL add_decode got=%h exp=%h", obs, e); end
        step(); memReady = 1'b1; #1;
        e = ev(2,0,0,0,0,0,0,1,0,0,1,0,0);
        checks++; if (obs !== e) begin errors++; $display("FAIL add_exec got=%h exp=%h", obs, e); end
        step(); memReady = 1'b0; #1;
        e = ev(0,0,0,0,1,0,0,0,0,0,0,0,0);
        checks++; if (obs !== e) begin errors++; $display("FAIL add_back_fetch got=%h exp=%h", obs, e); end
    endtask

    task automatic test_exec_variants();
        logic [7:0] ops [4];
        logic [2:0] exp_bits [4];   // {regWrite, aluSrcImm, flagsWrite}
        ops[0] = 8'hB0; exp_bits[0] = 3'b011;
        ops[1] = 8'hF0; exp_bits[1] = 3'b110;
        ops[2] = 8'h0B; exp_bits[2] = 3'b001;
        ops[3] = 8'h81; exp_bits[3] = 3'b110;
        for (int i = 0; i < 4; i++) begin
            instructionOp = ops[i]; memReady = 1'b1;
            step(); memReady = 1'b0;
            step(); #1;
            e = ev(2,0,0,0,0,0,0,exp_bits[i][2],0,exp_bits[i][1],exp_bits[i][0],0,0);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL exec_op%h got=%h exp=%h", ops[i], obs, e); end
            step();
        end
    endtask

    task automatic test_load_stor();
        instructionOp = 8'h40; memReady = 1'b1;
        step(); memReady = 1'b0;
        step();
        for (int c = 0; c < 4; c++) begin
            memReady = (c == 3); #1;
            e = ev(3,0,0,0,1,0,1,0,0,0,0,0,0);
            checks++; if (obs !== e) begin errors++; $display("FAIL load_mem%0d got=%h exp=%h", c, obs, e); end
            step();
        end
        memReady = 1'b0; #1;
        e = ev(4,0,0,0,0,0,0,1,1,0,0,0,0);
        checks++; if (obs !== e) begin errors++; $display("FAIL load_wb got=%h exp=%h", obs, e); end
        step();
        instructionOp = 8'h44; memReady = 1'b1;
        step(); memReady = 1'b0;
        step(); memReady = 1'b1; #1;
        e = ev(3,0,0,0,1,1,1,0,0,0,0,0,0);
        checks++; if (obs !== e) begin errors++; $display("FAIL stor_mem got=%h exp=%h", obs, e); end
        step(); memReady = 1'b0; #1;
        e = ev(0,0,0,0,1,0,0,0,0,0,0,0,0);
        checks++; if (obs !== e) begin errors++; $display("FAIL stor_no_wb got=%h exp=%h", obs, e); end
    endtask

    task automatic test_branches();
        logic [7:0] ops [6];
        logic       cnd [6];
        logic [16:0] exps [6];
        ops[0] = 8'hC0; cnd[0] = 1'b1; exps[0] = ev(1,1,1,0,0,0,0,0,0,0,0,0,0);
        ops[1] = 8'hC0; cnd[1] = 1'b0; exps[1] = ev(1,0,0,0,0,0,0,0,0,0,0,0,0);
        ops[2] = 8'h4C; cnd[2] = 1'b1; exps[2] = ev(1,1,2,0,0,0,0,0,0,0,0,0,0);
        ops[3] = 8'h4C; cnd[3] = 1'b0; exps[3] = ev(1,0,0,0,0,0,0,0,0,0,0,0,0);
        ops[4] = 8'h48; cnd[4] = 1'b0; exps[4] = ev(1,1,2,0,0,0,0,1,2,0,0,0,0);
        ops[5] = 8'h00; cnd[5] = 1'b1; exps[5] = ev(1,0,0,0,0,0,0,0,0,0,0,0,0);
        for (int i = 0; i < 6; i++) begin
            instructionOp = ops[i]; memReady = 1'b1; condTrue = 1'b0;
            step(); memReady = 1'b0; condTrue = cnd[i]; #1;
            checks++;
            if (obs !== exps[i]) begin
                errors++; $display("FAIL branch_op%h_c%0d got=%h exp=%h", ops[i], cnd[i], obs, exps[i]);
            end
            step(); #1;
            e = ev(0,0,0,0,1,0,0,0,0,0,0,0,0);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL branch_ret_op%h got=%h exp=%h", ops[i], obs, e); end
        end
        condTrue = 1'b0;
    endtask

    task automatic test_timeout_boundary();
        instructionOp = 8'h00; memReady = 1'b0;
        for (int c = 0; c < 4; c++) step();
        memReady = 1'b1; #1;
        e = ev(0,1,0,1,1,0,0,0,0,0,0,0,0);
        checks++; if (obs !== e) begin errors++; $display("FAIL to_edge_fetch got=%h exp=%h", obs, e); end
        step(); memReady = 1'b0; #1;
        e = ev(1,0,0,0,0,0,0,0,0,0,0,0,0);
        checks++; if (obs !== e) begin errors++; $display("FAIL to_edge_decode got=%h exp=%h", obs, e); end
        step();
    endtask

    task automatic test_timeout();
        memReady = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            e = ev(0,0,0,0,1,0,0,0,0,0,0,0,0);
            checks++; if (obs !== e) begin errors++; $display("FAIL to_wait%0d got=%h exp=%h", c, obs, e); end
            step();
        end
        #1;
        e = ev(5,0,0,0,0,0,0,0,0,0,0,1,1);
        checks++; if (obs !== e) begin errors++; $display("FAIL to_halt got=%h exp=%h", obs, e); end
        memReady = 1'b1; instructionOp = 8'h05;
        step(); step(); #1;
        checks++; if (obs !== e) begin errors++; $display("FAIL to_stuck got=%h exp=%h", obs, e); end
        reset = 1'b0; step(); reset = 1'b1; memReady = 1'b0; #1;
        e = ev(0,0,0,0,1,0,0,0,0,0,0,0,0);
        checks++; if (obs !== e) begin errors++; $display("FAIL to_reset_clear got=%h exp=%h", obs, e); end
    endtask

    task automatic test_illegal();
        instructionOp = 8'h07; memReady = 1'b1;
        step(); memReady = 1'b0; #1;
        e = ev(1,0,0,0,0,0,0,0,0,0,0,0,0);
        checks++; if (obs !== e) begin errors++; $display("FAIL illegal_decode got=%h exp=%h", obs, e); end
        step(); #1;
        e = ev(5,0,0,0,0,0,0,0,0,0,0,1,0);
        checks++; if (obs !== e) begin errors++; $display("FAIL illegal_halt got=%h exp=%h", obs, e); end
        $display("illegal op 07 -> state %0d halted %0b busError %0b", state, halted, busError);
    endtask

    initial begin
        test_reset();
        test_alu_add();
        test_exec_variants();
        test_load_stor();
        test_branches();
        test_timeout_boundary();
        test_timeout();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end
endmodule
